// File: rtl/mem_stage_sram_if.sv
// Pipeline-side load/store port of the MEM stage: request, address and store data go in; load data and the ready/stall flag come out.
// ready is combinational and drops while an access is in flight.
interface mem_stage_sram_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [31:0] rd_data;
    logic        ready;

    modport master (
        output mem_r_en, mem_w_en, alu_result, st_val,
        input  rd_data, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, alu_result, st_val,
        output rd_data, ready
    );
endinterface

// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit load/store as two half-word accesses on a 16-bit async SRAM.
// Latency 1 + 2*WAIT_CYCLES clocks; ready stays low (pipeline frozen) until DONE.
module mem_stage_sram #(
    parameter int WAIT_CYCLES = 3,
    parameter int ADDR_OFFSET = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    mem_stage_sram_if.slave    bus,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                req;
    logic                last;
    logic                active;
    logic                wr_drive;
    logic                is_wr;
    logic [31:0]         byte_off;
    logic [SRAM_AW-2:0]  waddr;
    logic [SRAM_AW-2:0]  waddr_lat;
    logic [31:0]         wdat_lat;

    assign req      = bus.mem_r_en | bus.mem_w_en;
    assign last     = (cnt == LAST);
    // Underflow below the data segment simply wraps; the pipeline never flags it.
    assign byte_off = bus.alu_result - 32'(ADDR_OFFSET);
    assign waddr    = byte_off[SRAM_AW:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            end
            LOW: begin
                if (last) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // rd_data doubles as the read buffer; each half lands as its SRAM access completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_wr       <= 1'b0;
            waddr_lat   <= '0;
            wdat_lat    <= '0;
            sram_addr   <= '0;
            bus.rd_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                is_wr     <= bus.mem_w_en;
                waddr_lat <= waddr;
                wdat_lat  <= bus.st_val;
                sram_addr <= {waddr, 1'b0};
            end
            if (state == LOW && last) begin
                sram_addr <= {waddr_lat, 1'b1};
                if (!is_wr) begin
                    bus.rd_data[15:0] <= sram_dq;
                end
            end
            if (state == HIGH && last && !is_wr) begin
                bus.rd_data[31:16] <= sram_dq;
            end
        end
    end

    // Strobes decode only from flops; we_n rises one cycle early so data is held past the write edge.
    assign active    = (state == LOW) || (state == HIGH);
    assign wr_drive  = active && is_wr;
    assign sram_we_n = ~(wr_drive && !last);
    assign sram_oe_n = ~(active && !is_wr);
    assign sram_dq   = wr_drive ? ((state == HIGH) ? wdat_lat[31:16] : wdat_lat[15:0]) : 16'bz;

    assign bus.ready = ~req | (state == DONE);
endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a behavioural async SRAM on the data bus.
module tb_mem_stage_sram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [15:0] mem [0:63];
    logic [15:0] model_q;
    logic        model_drv;
    logic        probe = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_sram_if bus();

    mem_stage_sram #(
        .WAIT_CYCLES(3),
        .ADDR_OFFSET(1024),
        .SRAM_AW(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sram_addr(sram_addr),
        .sram_dq(sram_dq),
        .sram_we_n(sram_we_n),
        .sram_oe_n(sram_oe_n)
    );

    // SRAM model: drives on read, samples the bus each cycle while we_n is low.
    assign model_q   = mem[sram_addr[5:0]];
    assign model_drv = !sram_oe_n && sram_we_n;
    assign sram_dq   = model_drv ? model_q : 16'bz;
    // Probe driver: reads back its own pattern only if nothing else is driving the bus.
    assign sram_dq   = probe ? 16'hA5A5 : 16'bz;

    always @(negedge clk) begin
        if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
    end

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
        bus.mem_r_en   = r;
        bus.mem_w_en   = w;
        bus.alu_result = a;
        bus.st_val     = v;
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'd1032, 32'h0BAD_F00D);
        repeat (2) @(negedge clk);
        n_tests++;
        if (sram_addr !== 18'd4) begin n_fail++; $display("FAIL rst_pre_addr: got %0d want 4", sram_addr); end
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        n_tests++;
        if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rst_we_n: got %b want 1", sram_we_n); end
        n_tests++;
        if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rst_oe_n: got %b want 1", sram_oe_n); end
        n_tests++;
        if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", sram_addr); end
        n_tests++;
        if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
        n_tests++;
        if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
        probe = 1'b1;
        #1;
        n_tests++;
        if (sram_dq !== 16'hA5A5) begin n_fail++; $display("FAIL rst_dq_z: got %h want a5a5", sram_dq); end
        probe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store;
        logic [17:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_dq;
        drive(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
        #1;
        n_tests++;
        if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL st_ready c0: got %b want 0", bus.ready); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_addr = (k <= 3) ? 18'd4 : 18'd5;
            exp_we   = (k == 1 || k == 2 || k == 4 || k == 5) ? 1'b0 : 1'b1;
            exp_dq   = (k <= 3) ? 16'hBEEF : 16'hDEAD;
            n_tests++;
            if (sram_we_n !== exp_we) begin n_fail++; $display("FAIL st_we_n c%0d: got %b want %b", k, sram_we_n, exp_we); end
            n_tests++;
            if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL st_oe_n c%0d: got %b want 1", k, sram_oe_n); end
            n_tests++;
            if (bus.ready !== (k == 7)) begin n_fail++; $display("FAIL st_ready c%0d: got %b want %b", k, bus.ready, (k == 7)); end
            if (k <= 6) begin
                n_tests++;
                if (sram_addr !== exp_addr) begin n_fail++; $display("FAIL st_addr c%0d: got %0d want %0d", k, sram_addr, exp_addr); end
                n_tests++;
                if (sram_dq !== exp_dq) begin n_fail++; $display("FAIL st_dq c%0d: got %h want %h", k, sram_dq, exp_dq); end
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if (mem[4] !== 16'hBEEF) begin n_fail++; $display("FAIL st_mem4: got %h want beef", mem[4]); end
        n_tests++;
        if (mem[5] !== 16'hDEAD) begin n_fail++; $display("FAIL st_mem5: got %h want dead", mem[5]); end
    endtask

    task automatic test_load;
        drive(1'b1, 1'b0, 32'd1032, 32'd0);
        #1;
        n_tests++;
        if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL ld_ready c0: got %b want 0", bus.ready); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (sram_oe_n !== (k == 7)) begin n_fail++; $display("FAIL ld_oe_n c%0d: got %b want %b", k, sram_oe_n, (k == 7)); end
            n_tests++;
            if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL ld_we_n c%0d: got %b want 1", k, sram_we_n); end
            n_tests++;
            if (bus.ready !== (k == 7)) begin n_fail++; $display("FAIL ld_ready c%0d: got %b want %b", k, bus.ready, (k == 7)); end
        end
        n_tests++;
        if (bus.rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld_rd_data: got %h want deadbeef", bus.rd_data); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic test_idle;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready c%0d: got %b want 1", k, bus.ready); end
            n_tests++;
            if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL idle_we_n c%0d: got %b want 1", k, sram_we_n); end
            n_tests++;
            if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL idle_oe_n c%0d: got %b want 1", k, sram_oe_n); end
        end
        probe = 1'b1;
        #1;
        n_tests++;
        if (sram_dq !== 16'hA5A5) begin n_fail++; $display("FAIL idle_dq_z: got %h want a5a5", sram_dq); end
        probe = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [17:0] exp_addr;
        logic [15:0] exp_dq;
        logic        exp_we;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd1032, 32'd0);
        repeat (7) @(negedge clk);
        n_tests++;
        if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ld_ready c7: got %b want 1", bus.ready); end
        n_tests++;
        if (bus.rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_ld_data: got %h want deadbeef", bus.rd_data); end
        drive(1'b0, 1'b1, 32'd1036, 32'h1234_5678);
        @(negedge clk);
        n_tests++;
        if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready c8: got %b want 0", bus.ready); end
        n_tests++;
        if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL b2b_we_n c8: got %b want 1", sram_we_n); end
        for (int k = 9; k <= 15; k++) begin
            @(negedge clk);
            exp_addr = (k <= 11) ? 18'd6 : 18'd7;
            exp_dq   = (k <= 11) ? 16'h5678 : 16'h1234;
            exp_we   = (k == 9 || k == 10 || k == 12 || k == 13) ? 1'b0 : 1'b1;
            n_tests++;
            if (bus.ready !== (k == 15)) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", k, bus.ready, (k == 15)); end
            n_tests++;
            if (sram_we_n !== exp_we) begin n_fail++; $display("FAIL b2b_we_n c%0d: got %b want %b", k, sram_we_n, exp_we); end
            if (k <= 14) begin
                n_tests++;
                if (sram_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr c%0d: got %0d want %0d", k, sram_addr, exp_addr); end
                n_tests++;
                if (sram_dq !== exp_dq) begin n_fail++; $display("FAIL b2b_dq c%0d: got %h want %h", k, sram_dq, exp_dq); end
            end
            // Disturb the inputs mid-access; the latched store must be unaffected.
            if (k == 9) drive(1'b0, 1'b1, 32'd1100, 32'hFFFF_FFFF);
        end
        n_tests++;
        if (bus.rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_rd_kept: got %h want deadbeef", bus.rd_data); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        n_tests++;
        if (mem[6] !== 16'h5678) begin n_fail++; $display("FAIL b2b_mem6: got %h want 5678", mem[6]); end
        n_tests++;
        if (mem[7] !== 16'h1234) begin n_fail++; $display("FAIL b2b_mem7: got %h want 1234", mem[7]); end
        n_tests++;
        if (mem[19] !== 16'h0000) begin n_fail++; $display("FAIL b2b_mem19: got %h want 0000", mem[19]); end
    endtask

    task automatic test_reset_in_high;
        drive(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D);
        repeat (4) @(negedge clk);
        n_tests++;
        if (sram_addr !== 18'd9) begin n_fail++; $display("FAIL rh_pre_addr: got %0d want 9", sram_addr); end
        n_tests++;
        if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL rh_pre_we_n: got %b want 0", sram_we_n); end
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        n_tests++;
        if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL rh_we_n: got %b want 1", sram_we_n); end
        n_tests++;
        if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL rh_oe_n: got %b want 1", sram_oe_n); end
        n_tests++;
        if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL rh_rd_data: got %h want 0", bus.rd_data); end
        probe = 1'b1;
        #1;
        n_tests++;
        if (sram_dq !== 16'hA5A5) begin n_fail++; $display("FAIL rh_dq_z: got %h want a5a5", sram_dq); end
        probe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd1032, 32'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.ready !== (k == 7)) begin n_fail++; $display("FAIL rh_lat_ready c%0d: got %b want %b", k, bus.ready, (k == 7)); end
        end
        n_tests++;
        if (bus.rd_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rh_ld_data: got %h want deadbeef", bus.rd_data); end
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        test_reset();
        test_store();
        test_load();
        test_idle();
        test_back_to_back();
        test_reset_in_high();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
